cpu_mc: RTL

CPU_MC -- requirements
Module: cpu_mc

---
 rtl/cpu_mc_pkg.sv | 69 ++++++
 rtl/cpu_mc_alu.sv | 29 ++
 rtl/cpu_mc.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle RV32 subset core: opcodes, ALU op codes,
// instruction classes, FSM states and the instruction classifier.
package cpu_mc_pkg;

   typedef enum logic [2:0] {S_IDLE, S_DEC, S_EX, S_MEM, S_WB} state_e;

   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT} alu_op_e;

   typedef enum logic [2:0] {K_RTYPE, K_ADDI, K_LW, K_SW, K_BEQ, K_ILLEGAL} kind_e;

   typedef struct packed {
      kind_e   kind;
      alu_op_e aluOp;
   } decode_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ADDI   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_WORD    = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   // Anything not explicitly recognised here is reported as illegal.
   function automatic decode_t decode(input logic [31:0] instr);
      decode_t    d;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op      = instr[6:0];
      f3      = instr[14:12];
      f7      = instr[31:25];
      d.kind  = K_ILLEGAL;
      d.aluOp = ALU_ADD;
      case (op)
         OP_RTYPE: begin
            if (f7 == F7_BASE) begin
               case (f3)
                  F3_ADD_SUB: begin d.kind = K_RTYPE; d.aluOp = ALU_ADD; end
                  F3_SLT:     begin d.kind = K_RTYPE; d.aluOp = ALU_SLT; end
                  F3_XOR:     begin d.kind = K_RTYPE; d.aluOp = ALU_XOR; end
                  F3_OR:      begin d.kind = K_RTYPE; d.aluOp = ALU_OR;  end
                  F3_AND:     begin d.kind = K_RTYPE; d.aluOp = ALU_AND; end
                  default:    d.kind = K_ILLEGAL;
               endcase
            end else if (f7 == F7_SUB && f3 == F3_ADD_SUB) begin
               d.kind  = K_RTYPE;
               d.aluOp = ALU_SUB;
            end
         end
         OP_ADDI:   if (f3 == F3_ADD_SUB) d.kind = K_ADDI;
         OP_LOAD:   if (f3 == F3_WORD)    d.kind = K_LW;
         OP_STORE:  if (f3 == F3_WORD)    d.kind = K_SW;
         OP_BRANCH: if (f3 == F3_BEQ) begin d.kind = K_BEQ; d.aluOp = ALU_SUB; end
         default:   d.kind = K_ILLEGAL;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational XLEN-wide ALU with a zero flag on the result.
module cpu_mc_alu
   import cpu_mc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  alu_op_e          op_i,
   input  logic [XLEN-1:0]  a_i,
   input  logic [XLEN-1:0]  b_i,
   output logic [XLEN-1:0]  result_o,
   output logic             zero_o
);

   always_comb begin
      result_o = '0;
      case (op_i)
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: result_o = a_i - b_i;
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_XOR: result_o = a_i ^ b_i;
         ALU_SLT: result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         default: result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle RV32 subset core (IDLE/DEC/EX/MEM/WB) with register file and data memory.
// Define CPU_MC_BYPASS_EN to retire R-type/ADDI directly from EX.
module cpu_mc
   import cpu_mc_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int NREG       = 32,
   parameter int DMEM_WORDS = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             retire,
   output logic [XLEN-1:0]  retire_data,
   output logic             zero,
   output logic             illegal
);

   localparam int RW = $clog2(NREG);
   localparam int AW = $clog2(DMEM_WORDS);

   state_e          state_q;
   logic [31:0]     instr_q;
   logic [XLEN-1:0] rs1v_q, rs2v_q, imm_q, res_q;
   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] mem_q  [DMEM_WORDS];
   logic            retire_q, zero_q, illegal_q;
   logic [XLEN-1:0] retireData_q;

   decode_t         dec;
   logic [RW-1:0]   rs1Idx, rs2Idx, rdIdx;
   logic [11:0]     immRaw;
   logic [XLEN-1:0] aluB, aluRes_d;
   logic            aluZero_d;
   logic [AW-1:0]   memIdx;

   assign dec    = decode(instr_q);
   assign rs1Idx = instr_q[15 +: RW];
   assign rs2Idx = instr_q[20 +: RW];
   assign rdIdx  = instr_q[7 +: RW];
   assign immRaw = (dec.kind == K_SW) ? {instr_q[31:25], instr_q[11:7]} : instr_q[31:20];
   assign aluB   = (dec.kind == K_RTYPE || dec.kind == K_BEQ) ? rs2v_q : imm_q;
   // Word address wraps: bits above the memory depth are simply dropped.
   assign memIdx = res_q[AW+1:2];

   cpu_mc_alu #(.XLEN(XLEN)) u_alu (
      .op_i     (dec.aluOp),
      .a_i      (rs1v_q),
      .b_i      (aluB),
      .result_o (aluRes_d),
      .zero_o   (aluZero_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         instr_q      <= '0;
         rs1v_q       <= '0;
         rs2v_q       <= '0;
         imm_q        <= '0;
         res_q        <= '0;
         retire_q     <= 1'b0;
         retireData_q <= '0;
         zero_q       <= 1'b0;
         illegal_q    <= 1'b0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         for (int i = 0; i < DMEM_WORDS; i++) mem_q[i] <= '0;
      end else begin
         retire_q  <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  instr_q <= in;
                  state_q <= S_DEC;
               end
            end
            S_DEC: begin
               if (dec.kind == K_ILLEGAL) begin
                  retire_q     <= 1'b1;
                  illegal_q    <= 1'b1;
                  retireData_q <= '0;
                  state_q      <= S_IDLE;
               end else begin
                  // Register 0 is hardwired to zero on the read side.
                  rs1v_q  <= (rs1Idx == '0) ? '0 : regs_q[rs1Idx];
                  rs2v_q  <= (rs2Idx == '0) ? '0 : regs_q[rs2Idx];
                  imm_q   <= {{(XLEN-12){immRaw[11]}}, immRaw};
                  state_q <= S_EX;
               end
            end
            S_EX: begin
               zero_q <= aluZero_d;
               res_q  <= aluRes_d;
               case (dec.kind)
                  K_BEQ: begin
                     retire_q     <= 1'b1;
                     retireData_q <= aluRes_d;
                     state_q      <= S_IDLE;
                  end
                  K_LW, K_SW: state_q <= S_MEM;
                  default: begin
`ifdef CPU_MC_BYPASS_EN
                     if (rdIdx != '0) regs_q[rdIdx] <= aluRes_d;
                     retire_q     <= 1'b1;
                     retireData_q <= aluRes_d;
                     state_q      <= S_IDLE;
`else
                     state_q <= S_WB;
`endif
                  end
               endcase
            end
            S_MEM: begin
               if (dec.kind == K_SW) begin
                  mem_q[memIdx] <= rs2v_q;
                  retire_q      <= 1'b1;
                  retireData_q  <= res_q;
                  state_q       <= S_IDLE;
               end else begin
                  res_q   <= mem_q[memIdx];
                  state_q <= S_WB;
               end
            end
            S_WB: begin
               if (rdIdx != '0) regs_q[rdIdx] <= res_q;
               retire_q     <= 1'b1;
               retireData_q <= res_q;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = (state_q == S_IDLE) && !rst;
   assign retire      = retire_q;
   assign retire_data = retireData_q;
   assign zero        = zero_q;
   assign illegal     = illegal_q;

endmodule
